// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit controller: FSM states, tx_out mux
// selects and parity-type codes.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    TxSelHigh   = 2'd0,
    TxSelLow    = 2'd1,
    TxSelData   = 2'd2,
    TxSelParity = 2'd3
  } tx_sel_e;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Request, serializer and line signals of the UART transmit controller.
// master: request source + serializer side; slave: the controller.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
  logic                  s_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output data_valid, p_data, par_en, par_typ, s_data, ser_done,
    input  ser_en, tx_out, busy
  );

  modport slave (
    input  data_valid, p_data, par_en, par_typ, s_data, ser_done,
    output ser_en, tx_out, busy
  );

endinterface

// File: rtl/parity_calc.sv
// Registered parity bit, captured from the request data when a frame is
// accepted so later p_data changes cannot disturb the frame in flight.
module parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  logic parity_d;
  logic parity_q;

  // Even parity is the XOR of the data bits, odd parity its complement.
  always_comb begin
    parity_d = parity_q;
    if (load_i) begin
      parity_d = (^data_i) ^ (par_typ_i == ParOdd);
    end
  end

  // Parity register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames data from an external serializer with a
// start bit, optional parity bit and STOP_BITS stop bits. Back-to-back frames
// are accepted in the last stop cycle with no idle gap.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic           clk,
  input logic           rst,
  uart_tx_ctrl_if.slave bus
);

  localparam logic StopLastCnt = 1'(STOP_BITS - 1);

  tx_state_e state_q, state_d;
  logic      par_en_q;
  logic      stop_cnt_q, stop_cnt_d;
  logic      stop_last;
  logic      accept;
  logic      parity;
  tx_sel_e   tx_sel;
  logic      ser_en;
  logic      busy;
  logic      tx_out;

  assign stop_last = (state_q == StStop) && (stop_cnt_q == StopLastCnt);
  assign accept    = bus.data_valid && ((state_q == StIdle) || stop_last);

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .data_i    (bus.p_data),
    .par_typ_i (bus.par_typ),
    .parity_o  (parity)
  );

  // Next-state, stop counter and Moore output decode.
  always_comb begin
    state_d    = state_q;
    stop_cnt_d = 1'b0;
    tx_sel     = TxSelHigh;
    ser_en     = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (accept) state_d = StStart;
      end
      StStart: begin
        tx_sel  = TxSelLow;
        ser_en  = 1'b1;
        state_d = StData;
      end
      StData: begin
        tx_sel = TxSelData;
        ser_en = 1'b1;
        if (bus.ser_done) state_d = par_en_q ? StParity : StStop;
      end
      StParity: begin
        tx_sel  = TxSelParity;
        state_d = StStop;
      end
      StStop: begin
        // Counter stays zero outside STOP, so every STOP entry starts at 0.
        stop_cnt_d = stop_last ? 1'b0 : stop_cnt_q + 1'b1;
        if (stop_last) state_d = accept ? StStart : StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Line mux: pure select of constant levels, serial bit and parity register.
  always_comb begin
    tx_out = 1'b1;
    unique case (tx_sel)
      TxSelHigh:   tx_out = 1'b1;
      TxSelLow:    tx_out = 1'b0;
      TxSelData:   tx_out = bus.s_data;
      TxSelParity: tx_out = parity;
      default:     tx_out = 1'b1;
    endcase
  end

  // State, stop counter and latched parity enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      stop_cnt_q <= stop_cnt_d;
      if (accept) par_en_q <= bus.par_en;
    end
  end

  assign bus.ser_en = ser_en;
  assign bus.busy   = busy;
  assign bus.tx_out = tx_out;

endmodule
